// File: rtl/inferred_ram_pkg.sv
// Shared SDU constants for the behavioural dual-port RAM and its consumers
// (e.g. the receive accumulator).
package inferred_ram_pkg;

  localparam int SDU_RAM_DWIDTH = 32;
  localparam int SDU_RAM_AWIDTH = 16;
  localparam int SDU_RAM_DEPTH  = 1 << SDU_RAM_AWIDTH;

endpackage

// File: rtl/inferred_ram.sv
// Simple dual-port RAM: one synchronous write port and one asynchronous read port.
// The array has no reset, so tools can infer distributed/LUT RAM.
module inferred_ram
  import inferred_ram_pkg::*;
#(
  parameter int DWIDTH = SDU_RAM_DWIDTH,
  parameter int AWIDTH = SDU_RAM_AWIDTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       rd_addr,
  output logic [DWIDTH-1:0] rd_data,
  input  logic [31:0]       wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              wr_en
);

  logic [DWIDTH-1:0] mem_q [(1 << AWIDTH)];
  logic [AWIDTH-1:0] rd_idx;
  logic [AWIDTH-1:0] wr_idx;

  // Upper address bits are dropped on purpose, so addresses wrap modulo the depth.
  assign rd_idx = rd_addr[AWIDTH-1:0];
  assign wr_idx = wr_addr[AWIDTH-1:0];

  // Read port: no bypass, so RMW loops see the old word until the edge.
  assign rd_data = mem_q[rd_idx];

  // The memory itself is never cleared. reset_n only blocks writes, and it is
  // sampled at the edge so that the array still infers as plain RAM.
  always_ff @(posedge clk) begin
    if (reset_n && wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  if (AWIDTH < 32) begin : g_upper
    logic unused_upper;
    assign unused_upper = ^{rd_addr[31:AWIDTH], wr_addr[31:AWIDTH]};
  end

endmodule

// File: tb/tb_inferred_ram.sv
// Directed bench for inferred_ram. Stimulus queues the expected read data and a
// negedge monitor compares it against rd_data.
module tb_inferred_ram;

  logic        clk;
  logic        reset_n;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [31:0] wr_data_s;
  logic        wr_en;
  logic        rmw;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  inferred_ram #(.DWIDTH(32), .AWIDTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_en   (wr_en)
  );

  // Read-modify-write mode feeds rd_data+3 back as the write data.
  assign wr_data = rmw ? (rd_data + 32'd3) : wr_data_s;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: at most one expectation is queued per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (rd_data !== e.val) begin
        errors++;
        $display("FAIL %s: rd_data=0x%08h expected=0x%08h", e.name, rd_data, e.val);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rd(input string name, input logic [31:0] val);
    exp_q.push_back('{name, val});
  endtask

  task automatic write(input logic [31:0] addr, input logic [31:0] data);
    wr_addr   = addr;
    wr_data_s = data;
    wr_en     = 1'b1;
    step();
    wr_en     = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    wr_en     = 1'b0;
    rmw       = 1'b0;
    rd_addr   = 32'd0;
    wr_addr   = 32'd0;
    wr_data_s = 32'd0;
    step();
    step();
    reset_n = 1'b1;

    // Basic write then same-cycle read after the edge.
    write(32'd5, 32'h0000_1234);
    rd_addr = 32'd5;
    expect_rd("wr_rd_addr5", 32'h0000_1234);
    step();

    // Read-modify-write accumulation on address 7.
    write(32'd7, 32'd10);
    rd_addr = 32'd7;
    wr_addr = 32'd7;
    rmw     = 1'b1;
    wr_en   = 1'b1;
    expect_rd("rmw_0", 32'd10);
    step();
    expect_rd("rmw_1", 32'd13);
    step();
    expect_rd("rmw_2", 32'd16);
    step();
    wr_en = 1'b0;
    rmw   = 1'b0;
    expect_rd("rmw_3", 32'd19);
    step();

    // Address aliasing on the write and read ports.
    write(32'h0001_0003, 32'hAAAA_AAAA);
    rd_addr = 32'h0000_0003;
    expect_rd("alias_wr", 32'hAAAA_AAAA);
    step();
    rd_addr = 32'h0002_0003;
    expect_rd("alias_rd", 32'hAAAA_AAAA);
    step();

    // A disabled write leaves the word untouched.
    write(32'd9, 32'h0000_0055);
    wr_addr   = 32'd9;
    wr_data_s = 32'hFFFF_FFFF;
    rd_addr   = 32'd9;
    expect_rd("wr_en0_a", 32'h0000_0055);
    step();
    expect_rd("wr_en0_b", 32'h0000_0055);
    step();

    // Reset suppresses writes and preserves contents.
    write(32'd2, 32'h0000_0001);
    reset_n   = 1'b0;
    wr_addr   = 32'd2;
    wr_data_s = 32'h0000_DEAD;
    wr_en     = 1'b1;
    rd_addr   = 32'd2;
    expect_rd("rst_hold_a", 32'h0000_0001);
    step();
    expect_rd("rst_hold_b", 32'h0000_0001);
    step();
    rd_addr = 32'd5;
    expect_rd("rst_keep5", 32'h0000_1234);
    step();
    // First edge after release must already write.
    reset_n   = 1'b1;
    rd_addr   = 32'd2;
    wr_data_s = 32'h0000_BEEF;
    expect_rd("rst_after", 32'h0000_0001);
    step();
    wr_en = 1'b0;
    expect_rd("rst_beef", 32'h0000_BEEF);
    step();

    // Independent ports: write address 0 while reading top of memory.
    write(32'h0000_FFFF, 32'h0000_0022);
    wr_addr   = 32'd0;
    wr_data_s = 32'h0000_0011;
    wr_en     = 1'b1;
    rd_addr   = 32'h0000_FFFF;
    expect_rd("dual_rd_top", 32'h0000_0022);
    step();
    wr_en = 1'b0;
    expect_rd("dual_rd_top2", 32'h0000_0022);
    step();
    rd_addr = 32'd0;
    expect_rd("dual_wr0", 32'h0000_0011);
    step();
    rd_addr = 32'd7;
    expect_rd("keep7", 32'd19);
    step();

    step();
    step();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
